// File: rtl/instruction_encoder_if.sv
// instruction_encoder_if: load control, decoded-field stream and imem write bus of the encoder
interface instruction_encoder_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 start;
  logic [11:0]          base_addr;
  logic [12:0]          count;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           inst_type;
  logic [4:0]           rd;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [31:0]          imm;
  logic [11:0]          csr;
  logic                 imem_we;
  logic [11:0]          imem_addr;
  logic [31:0]          imem_wdata;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;
  modport master (
    output start, base_addr, count, in_valid, inst_type, rd, rs1, rs2, funct3, funct7, imm, csr,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_cnt
  );
  modport slave (
    input  start, base_addr, count, in_valid, inst_type, rd, rs1, rs2, funct3, funct7, imm, csr,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_cnt
  );
endinterface

// File: rtl/instruction_encoder.sv
// instruction_encoder: encodes decoded RV32 field bundles and writes them to consecutive imem words
module instruction_encoder #(
  parameter logic [31:0] NOP_WORD  = 32'h00000013,
  parameter int          ERR_CNT_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  instruction_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t               r_state;
  logic [11:0]          r_addr;
  logic [12:0]          r_rem;
  logic                 r_we;
  logic [11:0]          r_waddr;
  logic [31:0]          r_wdata;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_hs;
  logic                 w_shift;
  logic                 w_s12;
  logic                 w_s13;
  logic                 w_s21;
  logic                 w_al;
  logic                 w_bad;
  logic [31:0]          w_enc;
  logic [31:0]          w_word;
  assign bus.in_ready   = r_state == LOAD && r_rem != 13'd0;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_waddr;
  assign bus.imem_wdata = r_wdata;
  assign bus.busy       = r_state != IDLE;
  assign bus.done       = r_state == DONE;
  assign bus.err        = r_err;
  assign bus.err_cnt    = r_err_cnt;
  assign w_hs    = bus.in_valid && bus.in_ready;
  assign w_shift = bus.funct3 == 3'b001 || bus.funct3 == 3'b101;
  // signed-range checks: upper bits must be a pure sign extension
  assign w_s12   = &bus.imm[31:11] || ~|bus.imm[31:11];
  assign w_s13   = &bus.imm[31:12] || ~|bus.imm[31:12];
  assign w_s21   = &bus.imm[31:20] || ~|bus.imm[31:20];
  assign w_al    = bus.imm[1:0] == 2'b00;
  assign w_word  = w_bad ? NOP_WORD : w_enc;
  always_comb begin
    w_enc = NOP_WORD;
    w_bad = 1'b1;
    case (bus.inst_type)
      3'b000: begin
        w_enc = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
        w_bad = 1'b0;
      end
      3'b001: begin
        w_enc = w_shift ? {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011}
                        : {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
        w_bad = w_shift ? |bus.imm[31:5] : !w_s12;
      end
      3'b010: begin
        w_enc = {bus.imm[31:12], bus.rd, 7'b0110111};
        w_bad = |bus.imm[11:0];
      end
      3'b011: begin
        w_enc = {bus.csr, bus.rs1, bus.funct3, bus.rd, 7'b1110011};
        w_bad = 1'b0;
      end
      3'b100: begin
        w_enc = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:1], bus.imm[11], 7'b1100011};
        w_bad = !w_s13 || !w_al;
      end
      3'b101: begin
        w_enc = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, 7'b1101111};
        w_bad = !w_s21 || !w_al;
      end
      3'b110: begin
        w_enc = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b1100111};
        w_bad = !w_s12;
      end
      default: begin
        w_enc = NOP_WORD;
        w_bad = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_we <= w_hs;
      if (w_hs) begin
        r_waddr <= r_addr;
        r_wdata <= w_word;
        r_addr  <= r_addr + 12'd1;
        r_rem   <= r_rem - 13'd1;
        if (w_bad) begin
          r_err     <= 1'b1;
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(!(&r_err_cnt));
        end
      end
      case (r_state)
        IDLE: if (bus.start) begin
          r_addr    <= bus.base_addr;
          r_rem     <= bus.count;
          r_err     <= 1'b0;
          r_err_cnt <= '0;
          r_state   <= bus.count != 13'd0 ? LOAD : DONE;
        end
        LOAD:    r_state <= w_hs && r_rem == 13'd1 ? DONE : LOAD;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
